// File: rtl/systolic_ws_array.sv
// Weight-stationary INT8 systolic array with built-in input skew, output de-skew,
// a weight-load FSM, valid/ready streaming and a per-column requantiser.
`timescale 1ns/1ps
module systolic_ws_array #(
  parameter int PE_ROW            = 16,
  parameter int PE_COL            = 16,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int OUTPUT_DATA_WIDTH = 20,
  parameter int SHIFT_WIDTH       = 5
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [SHIFT_WIDTH-1:0]                cfg_shift,
  input  logic                                  cfg_round,
  input  logic                                  cfg_relu,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [WEIGHT_DATA_WIDTH*PE_COL-1:0]   w_data,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0]    a_data,
  input  logic                                  a_last,
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic [INPUT_DATA_WIDTH*PE_COL-1:0]    o_data,
  output logic                                  o_last,
  output logic                                  busy
);

  localparam int IW = INPUT_DATA_WIDTH;
  localparam int WW = WEIGHT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int SW = SHIFT_WIDTH;
  localparam int N  = PE_ROW + PE_COL;
  localparam int CW = (PE_ROW > 1) ? $clog2(PE_ROW) : 1;
  localparam logic signed [OW:0] SAT_MAX = (OW+1)'((1 << (IW-1)) - 1);
  localparam logic signed [OW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [SW-1:0]     shift_q;
  logic              round_q, relu_q;
  logic [N-1:0]      tag_q, last_q;
  logic [IW*PE_COL-1:0] odata_q;
  logic [IW*PE_COL-1:0] rq_d;

  logic adv, a_fire, w_fire, w_last_beat, out_last_hs;

  logic signed [IW-1:0] a_pipe [PE_ROW][PE_COL];
  logic signed [OW-1:0] p_pipe [PE_ROW+1][PE_COL];
  logic signed [OW-1:0] col_out [PE_COL];

  assign o_valid     = rstn & tag_q[N-1];
  assign o_last      = rstn & last_q[N-1];
  assign o_data      = rstn ? odata_q : '0;
  assign adv         = !(o_valid & !o_ready);
  assign a_fire      = a_valid & a_ready;
  assign w_fire      = w_valid & w_ready;
  assign w_last_beat = (wcnt_q == CW'(PE_ROW-1));
  assign out_last_hs = o_valid & o_ready & o_last;

  always_comb begin
    a_ready = 1'b0;
    w_ready = 1'b0;
    busy    = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE:  w_ready = 1'b1;
        LOAD:  begin w_ready = 1'b1; busy = 1'b1; end
        HOLD:  begin a_ready = 1'b1; w_ready = !a_valid; end
        RUN:   begin a_ready = adv; busy = 1'b1; end
        FLUSH: busy = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (w_fire) begin
          if (w_last_beat) begin
            state_d = HOLD;
            wcnt_d  = '0;
          end else begin
            state_d = LOAD;
            wcnt_d  = wcnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (a_fire) begin
          state_d = a_last ? FLUSH : RUN;
        end else if (w_fire) begin
          if (w_last_beat) begin
            state_d = HOLD;
            wcnt_d  = '0;
          end else begin
            state_d = LOAD;
            wcnt_d  = wcnt_q + CW'(1);
          end
        end
      end
      RUN:   if (a_fire && a_last) state_d = FLUSH;
      FLUSH: if (out_last_hs) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      shift_q <= '0;
      round_q <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == HOLD && a_fire) begin
        shift_q <= cfg_shift;
        round_q <= cfg_round;
        relu_q  <= cfg_relu;
      end
    end
  end

  // Tags and last flags ride alongside the data so o_valid lines up with o_data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_q   <= '0;
      last_q  <= '0;
      odata_q <= '0;
    end else if (adv) begin
      tag_q   <= {tag_q[N-2:0], a_fire};
      last_q  <= {last_q[N-2:0], a_fire & a_last};
      odata_q <= rq_d;
    end
  end

  // Row i enters the array i cycles late; row 0 feeds its PE combinationally.
  for (genvar i = 0; i < PE_ROW; i++) begin : g_skew
    logic signed [IW-1:0] a_in;
    assign a_in = a_fire ? a_data[i*IW +: IW] : '0;
    if (i == 0) begin : g_direct
      assign a_pipe[i][0] = a_in;
    end else begin : g_delay
      logic signed [IW-1:0] sr_q [i];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < i; k++) sr_q[k] <= '0;
        end else if (adv) begin
          sr_q[0] <= a_in;
          for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign a_pipe[i][0] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < PE_COL; j++) begin : g_top
    assign p_pipe[0][j] = '0;
  end

  for (genvar i = 0; i < PE_ROW; i++) begin : g_row
    for (genvar j = 0; j < PE_COL; j++) begin : g_pe
      logic signed [WW-1:0]    w_q;
      logic signed [OW-1:0]    psum_q;
      logic signed [IW+WW-1:0] prod;
      assign prod = a_pipe[i][j] * w_q;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          w_q    <= '0;
          psum_q <= '0;
        end else begin
          if (w_fire && wcnt_q == CW'(i)) w_q <= w_data[j*WW +: WW];
          if (adv) psum_q <= p_pipe[i][j] + OW'(prod);
        end
      end
      assign p_pipe[i+1][j] = psum_q;
      if (j < PE_COL-1) begin : g_act
        logic signed [IW-1:0] act_q;
        always_ff @(posedge clk) begin
          if (!rstn)    act_q <= '0;
          else if (adv) act_q <= a_pipe[i][j];
        end
        assign a_pipe[i][j+1] = act_q;
      end
    end
  end

  function automatic logic signed [IW-1:0] requant(input logic signed [OW-1:0] acc,
                                                   input logic [SW-1:0] sh,
                                                   input logic rnd,
                                                   input logic relu);
    logic signed [OW:0] t;
    logic signed [OW:0] s;
    t = {acc[OW-1], acc};
    if (rnd && sh != '0) t = t + ({{OW{1'b0}}, 1'b1} << (sh - 1'b1));
    s = t >>> sh;
    if (relu && s[OW]) s = '0;
    if (s > SAT_MAX)      requant = SAT_MAX[IW-1:0];
    else if (s < SAT_MIN) requant = SAT_MIN[IW-1:0];
    else                  requant = s[IW-1:0];
  endfunction

  // Column j waits PE_COL-1-j cycles so every column of a vector leaves together.
  for (genvar j = 0; j < PE_COL; j++) begin : g_deskew
    localparam int D = PE_COL - 1 - j;
    if (D == 0) begin : g_direct
      assign col_out[j] = p_pipe[PE_ROW][j];
    end else begin : g_delay
      logic signed [OW-1:0] ds_q [D];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < D; k++) ds_q[k] <= '0;
        end else if (adv) begin
          ds_q[0] <= p_pipe[PE_ROW][j];
          for (int k = 1; k < D; k++) ds_q[k] <= ds_q[k-1];
        end
      end
      assign col_out[j] = ds_q[D-1];
    end
    assign rq_d[j*IW +: IW] = requant(col_out[j], shift_q, round_q, relu_q);
  end

endmodule

// File: tb/tb_systolic_ws_array.sv
// Scoreboard bench for systolic_ws_array: directed vectors push expected outputs,
// an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_systolic_ws_array;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int OW = 20;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic [SW-1:0]     cfg_shift;
  logic              cfg_round, cfg_relu;
  logic              w_valid, w_ready;
  logic [WW*C-1:0]   w_data;
  logic              a_valid, a_ready, a_last;
  logic [IW*R-1:0]   a_data;
  logic              o_valid, o_ready, o_last;
  logic [IW*C-1:0]   o_data;
  logic              busy;

  systolic_ws_array #(
    .PE_ROW(R), .PE_COL(C), .INPUT_DATA_WIDTH(IW), .WEIGHT_DATA_WIDTH(WW),
    .OUTPUT_DATA_WIDTH(OW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_shift(cfg_shift), .cfg_round(cfg_round),
    .cfg_relu(cfg_relu), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [IW*C-1:0] data;
    logic            last;
    int              accCycle;
    bit              chkLat;
  } expT;

  expT             expQ[$];
  int              checks = 0;
  int              errors = 0;
  int              outCount = 0;
  bit              prevStall = 0;
  logic [IW*C-1:0] heldData;
  logic            heldLast;
  logic [WW*C-1:0] wRows [R];
  int              vA [16];
  int              vE [16];

  task automatic checkVal(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkVec(input string name, input logic [IW*C-1:0] act, input logic [IW*C-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW*16-1:0] pack(input int v [16]);
    logic [IW*16-1:0] res;
    for (int i = 0; i < 16; i++) res[i*IW +: IW] = IW'(v[i]);
    return res;
  endfunction

  task automatic checkOutput();
    expT e;
    if (prevStall) begin
      checkVal("hold_valid", o_valid, 1);
      checkVec("hold_data", o_data, heldData);
      checkVal("hold_last", o_last, heldLast);
    end
    if (o_valid && o_ready) begin
      outCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h expected none", o_data);
      end else begin
        e = expQ.pop_front();
        checkVec("o_data", o_data, e.data);
        checkVal("o_last", o_last, e.last);
        if (e.chkLat) checkVal("latency", cycle - e.accCycle, R + C);
      end
    end
    prevStall = o_valid && !o_ready;
    heldData  = o_data;
    heldLast  = o_last;
  endtask

  always @(negedge clk) begin
    if (rstn) checkOutput();
    else      prevStall = 0;
  end

  task automatic applyStimulus(input logic [IW*R-1:0] a, input logic last,
                               input logic [IW*C-1:0] expD, input bit chkLat);
    expT e;
    bit  done = 0;
    a_valid = 1'b1;
    a_data  = a;
    a_last  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (a_ready) begin
        e.data = expD; e.last = last; e.accCycle = cycle; e.chkLat = chkLat;
        expQ.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got a_ready=0 expected 1 within 200 cycles");
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic loadWeights();
    for (int r = 0; r < R; r++) begin
      bit done = 0;
      if (r % 5 == 2) begin
        w_valid = 1'b0;
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      w_data  = wRows[r];
      for (int t = 0; t < 50 && !done; t++) begin
        @(negedge clk);
        if (w_ready) done = 1;
        @(posedge clk); #1;
      end
      if (!done) checkVal("w_accept_timeout", 0, 1);
    end
    w_valid = 1'b0;
    @(negedge clk);
    checkVal("load_busy", busy, 0);
    checkVal("load_a_ready", a_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy) done = 1;
      @(posedge clk); #1;
    end
    if (!done) checkVal("drain_timeout", expQ.size(), 0);
  endtask

  task automatic setAllWeights(input int val);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wRows[r][c*WW +: WW] = WW'(val);
  endtask

  task automatic setCfg(input int sh, input logic rnd, input logic relu);
    cfg_shift = SW'(sh);
    cfg_round = rnd;
    cfg_relu  = relu;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    rstn = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    a_last = 1'b0; o_ready = 1'b1;
    setCfg(0, 1'b0, 1'b0);

    // Reset values while held and on the cycle after release.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst_o_valid", o_valid, 0);
    checkVal("rst_o_last", o_last, 0);
    checkVec("rst_o_data", o_data, '0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_a_ready", a_ready, 0);
    checkVal("rst_w_ready", w_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkVal("post_rst_o_valid", o_valid, 0);
    checkVal("post_rst_busy", busy, 0);
    checkVal("post_rst_a_ready", a_ready, 0);
    checkVal("post_rst_w_ready", w_ready, 1);
    @(posedge clk); #1;

    // Identity weights, a=[1..16], exact latency, return to HOLD.
    $display("[TB] identity pass-through");
    setAllWeights(0);
    for (int r = 0; r < R; r++) wRows[r][r*WW +: WW] = WW'(1);
    loadWeights();
    for (int i = 0; i < 16; i++) vA[i] = i + 1;
    applyStimulus(pack(vA), 1'b1, pack(vA), 1'b1);
    waitDrain();
    @(negedge clk);
    checkVal("hold_busy", busy, 0);
    checkVal("hold_a_ready", a_ready, 1);
    checkVal("hold_w_ready", w_ready, 1);
    @(posedge clk); #1;

    // Bidiagonal weights give o[j] = a[j] + a[j+1]; 40-vector batch with a stall.
    $display("[TB] 40-vector batch with downstream stall");
    setAllWeights(0);
    for (int r = 0; r < R; r++) begin
      wRows[r][r*WW +: WW] = WW'(1);
      if (r > 0) wRows[r][(r-1)*WW +: WW] = WW'(1);
    end
    loadWeights();
    setCfg(0, 1'b0, 1'b0);
    base = outCount;
    fork
      begin
        for (int v = 0; v < 40; v++) begin
          for (int i = 0; i < 16; i++) vA[i] = ((v * 7 + i * 5) % 41) - 20;
          for (int j = 0; j < 16; j++) vE[j] = (j < 15) ? vA[j] + vA[j+1] : vA[j];
          applyStimulus(pack(vA), v == 39, pack(vE), 1'b0);
          if (v == 0) setCfg(3, 1'b1, 1'b1);
        end
      end
      begin
        for (int t = 0; t < 300 && outCount < base + 5; t++) @(posedge clk);
        #1;
        o_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkVal("stall_a_ready", a_ready, 0);
          @(posedge clk); #1;
        end
        o_ready = 1'b1;
      end
    join
    waitDrain();
    checkVal("batch_count", outCount - base, 40);

    // Saturation: all 127 weights with +127 and -128 activations, shift 7.
    $display("[TB] saturation");
    setAllWeights(127);
    loadWeights();
    setCfg(7, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin vA[i] = 127; vE[i] = 127; end
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();
    for (int i = 0; i < 16; i++) begin vA[i] = -128; vE[i] = -128; end
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();

    // Rounding and ReLU on a single nonzero weight.
    $display("[TB] rounding and relu");
    setAllWeights(0);
    wRows[0][WW-1:0] = WW'(1);
    loadWeights();
    for (int i = 0; i < 16; i++) begin vA[i] = 0; vE[i] = 0; end
    vA[0] = -3;
    setCfg(1, 1'b0, 1'b0);
    vE[0] = -2;
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();
    setCfg(1, 1'b1, 1'b0);
    vE[0] = -1;
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();
    setCfg(1, 1'b0, 1'b1);
    vE[0] = 0;
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();

    // Reload all-2 weights from HOLD; a w_valid pulse in RUN must be refused.
    $display("[TB] reload and run-time weight refusal");
    setAllWeights(2);
    loadWeights();
    setCfg(0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin vA[i] = i + 1; vE[i] = 127; end
    applyStimulus(pack(vA), 1'b0, pack(vE), 1'b0);
    w_valid = 1'b1;
    w_data  = '0;
    @(negedge clk);
    checkVal("run_w_ready", w_ready, 0);
    checkVal("run_busy", busy, 1);
    @(posedge clk); #1;
    w_valid = 1'b0;
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    waitDrain();

    // Reset in FLUSH discards the in-flight vector.
    $display("[TB] reset during flush");
    applyStimulus(pack(vA), 1'b1, pack(vE), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    checkVal("flush_rst_w_ready", w_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkVal("flush_rst_o_valid", o_valid, 0);
    checkVal("flush_rst_busy", busy, 0);
    checkVal("flush_rst_a_ready", a_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("flush_rst_w_ready_after", w_ready, 1);
    @(posedge clk); #1;
    repeat (60) @(posedge clk);
    #1;
    checkVal("flush_rst_no_output", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
